pc_gen: RTL
===========

// Module: pc_gen
// PURPOSE
//  Parametrised fetch program-counter generator for the RV core front end.
//  Produces the fetch PC, with advance gated by a fetch valid/ready handshake.
//  Accepts branch/jump redirects and trap entry, and checks target alignment.
//  Supports halt/resume. Sits between execute/CSR redirect logic and the I-fetch port.
// PARAMETERS
//  XLEN          32            PC width in bits
//  RESET_VECTOR  32'h0000_0000 PC loaded on reset
//  TRAP_VECTOR   32'h0000_0100 PC loaded on trap or on a misaligned redirect
//  INC           4             sequential increment, in bytes
//  ALIGN_BITS    2             low target bits that must be zero (1 = compressed ISA)
// PORTS
//  clk              in   1     clock, rising edge
//  reset            in   1     asynchronous, active-high
//  fetch_ready      in   1     I-fetch accepts the current pc this cycle
//  redirect_valid   in   1     jump/branch taken (jal, jalr, branch)
//  redirect_target  in   XLEN  redirect destination
//  trap_valid       in   1     exception/interrupt entry request
//  halt_req         in   1     request to stop fetching
//  resume           in   1     leave HALT
//  pc               out  XLEN  current fetch PC (registered)
//  pc_next_seq      out  XLEN  pc + INC, combinational, modulo 2^XLEN
//  fetch_valid      out  1     pc is a valid fetch request
//  misaligned_exc   out  1     one-cycle pulse: a redirect target was misaligned
//  bad_addr         out  XLEN  last misaligned target (held until the next one)
//  halted           out  1     state == HALT
// BEHAVIOUR
//  - Reset (async assert, sync release) sets the following values:
//      pc = RESET_VECTOR, state = BOOT, fetch_valid = 0, misaligned_exc = 0,
//      bad_addr = 0, halted = 0.
//  - State BOOT:
//      lasts exactly one cycle, then goes to RUN.
//      fetch_valid = 0.
//      Redirects are ignored.
//  - State RUN:
//      fetch_valid = 1.
//      Per-cycle priority, highest first: trap > redirect > halt > advance.
//      trap_valid: pc <= TRAP_VECTOR.
//      redirect_valid with target[ALIGN_BITS-1:0] == 0: pc <= redirect_target.
//      redirect_valid with target misaligned:
//        pc <= TRAP_VECTOR, bad_addr <= target, misaligned_exc = 1 next cycle.
//      halt_req: state <= HALT, pc holds.
//      Otherwise fetch_ready = 1: pc <= pc + INC.
//      Otherwise: pc holds.
//  - Redirect and trap do not depend on fetch_ready; they take effect even while fetch stalls.
//  - State HALT:
//      fetch_valid = 0, halted = 1.
//      trap_valid: pc <= TRAP_VECTOR and state <= RUN (wake on interrupt).
//      resume: state <= RUN with pc unchanged.
//      redirect_valid: ignored.
//  - Latency: every pc update is visible on the cycle after the triggering edge.
//  - Arithmetic: pc + INC wraps modulo 2^XLEN (all-ones region + INC -> low addresses); no flag.
//  - Simultaneous events:
//      trap + redirect -> trap wins, no misaligned check.
//      halt_req + redirect -> redirect is taken and the halt is dropped; the requester re-asserts.
//  - Reset asserted mid-operation overrides everything immediately (asynchronous).
//  - misaligned_exc is never asserted two cycles in a row for one event.
//  - RESET_VECTOR and TRAP_VECTOR must be aligned; checked by an elaboration-time assertion.
// TESTING
//  1. Reset, fetch_ready = 1:
//     -> pc = 0 during BOOT, then 0, 4, 8, C on successive cycles with fetch_valid = 1.
//  2. fetch_ready = 0 for 3 cycles at pc = 0x10:
//     -> pc holds at 0x10.
//     -> redirect_valid to 0x200 during the stall gives pc = 0x200 on the next cycle.
//  3. Redirect to 0x202 with ALIGN_BITS = 2:
//     -> pc = 0x100, misaligned_exc pulses 1 cycle, bad_addr = 0x202.
//     -> With ALIGN_BITS = 1: pc = 0x202, no exception.
//  4. trap_valid and redirect_valid (0x400) in the same cycle:
//     -> pc = 0x100 and misaligned_exc = 0.
//  5. halt_req at pc = 0x20:
//     -> halted = 1, fetch_valid = 0, pc stays 0x20 for 5 cycles.
//     -> resume gives pc = 0x20, then 0x24.
//     -> A trap while halted gives pc = 0x100 and RUN.
//  6. pc = 0xFFFF_FFFC with fetch_ready = 1:
//     -> pc wraps to 0x0.
//     -> reset asserted mid-stall gives pc = RESET_VECTOR asynchronously and state BOOT.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator for the RV core front end.
// Sequences the fetch PC and applies redirect, trap entry and halt/resume.
module pc_gen #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
   parameter int              INC          = 4,
   parameter int              ALIGN_BITS   = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            fetch_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap_valid,
   input  logic            halt_req,
   input  logic            resume,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_next_seq,
   output logic            fetch_valid,
   output logic            misaligned_exc,
   output logic [XLEN-1:0] bad_addr,
   output logic            halted
);

   localparam logic [1:0] S_BOOT = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   localparam logic [XLEN-1:0] ALIGN_MASK =
      XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
   localparam logic [XLEN-1:0] INC_W = XLEN'(INC);

   // Vectors must satisfy the same alignment as any redirect target.
   if ((RESET_VECTOR & ALIGN_MASK) != '0) begin : g_bad_reset_vec
      $error("pc_gen: RESET_VECTOR is misaligned");
   end
   if ((TRAP_VECTOR & ALIGN_MASK) != '0) begin : g_bad_trap_vec
      $error("pc_gen: TRAP_VECTOR is misaligned");
   end

   logic [1:0]      state, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] bad_q, bad_d;
   logic            mis_q, mis_d;
   logic            tgt_mis;

   assign tgt_mis     = (redirect_target & ALIGN_MASK) != '0;
   assign pc          = pc_q;
   assign pc_next_seq = pc_q + INC_W;
   assign fetch_valid = (state == S_RUN);
   assign halted      = (state == S_HALT);
   assign misaligned_exc = mis_q;
   assign bad_addr    = bad_q;

   // Next-state and next-pc selection; trap > redirect > halt > advance.
   always_comb begin
      state_d = state;
      pc_d    = pc_q;
      bad_d   = bad_q;
      mis_d   = 1'b0;
      unique case (state)
         S_BOOT: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (trap_valid) begin
               pc_d = TRAP_VECTOR;
            end else if (redirect_valid) begin
               if (tgt_mis) begin
                  pc_d  = TRAP_VECTOR;
                  bad_d = redirect_target;
                  mis_d = 1'b1;
               end else begin
                  pc_d = redirect_target;
               end
            end else if (halt_req) begin
               state_d = S_HALT;
            end else if (fetch_ready) begin
               pc_d = pc_next_seq;
            end
         end
         S_HALT: begin
            if (trap_valid) begin
               pc_d    = TRAP_VECTOR;
               state_d = S_RUN;
            end else if (resume) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_BOOT;
         end
      endcase
   end

   // State, pc and exception registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_BOOT;
         pc_q  <= RESET_VECTOR;
         bad_q <= '0;
         mis_q <= 1'b0;
      end else begin
         state <= state_d;
         pc_q  <= pc_d;
         bad_q <= bad_d;
         mis_q <= mis_d;
      end
   end

endmodule
